cla_pipe_adder: RTL and testbench

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

---
 rtl/cla_pipe_adder_pkg.sv | 44 ++++
 rtl/cla_group_carry.sv | 27 ++
 rtl/cla_pipe_adder.sv | 155 +++++++++++++++
 tb/tb_cla_pipe_adder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pipe_adder_pkg.sv
// Shared definitions for the two-stage carry-lookahead adder/subtractor:
// operand and group geometry, the add/subtract encoding of alu_op2, the
// stage-1 register layout and the 4-bit group propagate/generate helper.
package cla_pipe_adder_pkg;

    localparam int GRP_W  = 4;               // bits per lookahead group
    localparam int GRP_N  = 4;               // number of groups
    localparam int DATA_W = GRP_W * GRP_N;   // operand width (16)

    // Encoding of the alu_op2 input.
    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;

    // Group propagate / generate pair.
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Everything stage 2 needs, captured at the stage-1 register.
    typedef struct packed {
        logic [DATA_W-1:0] p;    // per-bit propagate a ^ b'
        logic [DATA_W-1:0] g;    // per-bit generate  a & b'
        logic [GRP_N-1:0]  gp;   // group propagate
        logic [GRP_N-1:0]  gg;   // group generate
        logic              cin;  // 1 for subtract (two's complement +1)
    } s1_t;

    // Collapse one group's bit P/G into a group P/G.
    // Group generate folds from LSB upward: G = g3 | p3&(g2 | p2&(g1 | p1&g0)).
    function automatic pg_t group_pg(input logic [GRP_W-1:0] p,
                                     input logic [GRP_W-1:0] g);
        pg_t r;
        r.p = &p;
        r.g = 1'b0;
        for (int i = 0; i < GRP_W; i++) begin
            r.g = g[i] | (p[i] & r.g);
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_group_carry.sv
// Second-level carry lookahead: turns the four group P/G pairs and the
// carry-in into the carries entering groups 1..3 and the final carry out.
// Purely combinational.
module cla_group_carry
    import cla_pipe_adder_pkg::*;
(
    input  logic [GRP_N-1:0] gp,
    input  logic [GRP_N-1:0] gg,
    input  logic             cin,
    output logic             c4,
    output logic             c8,
    output logic             c12,
    output logic             c16
);

    // Flat sum-of-products lookahead so no group carry waits on another.
    always_comb begin
        c4  = gg[0] | (gp[0] & cin);
        c8  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        c12 = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & cin);
        c16 = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined 16-bit carry-lookahead adder/subtractor with a
// valid/ready handshake on both sides and a wrapping count of results taken.
//   Stage 1: operand conditioning (b inverted for subtract) and bit/group P/G.
//   Stage 2: group carries by lookahead, ripple inside groups, result flags.
// Optional build macro: OVERFLOW_DETECT_EN adds the signed 'overflow' output.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              alu_op2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              zero,
`ifdef OVERFLOW_DETECT_EN
    output logic              overflow,
`endif
    output logic [CNT_W-1:0]  op_count
);

    alu_op_e           op;
    logic [DATA_W-1:0] b_eff;
    s1_t               s1_d;
    s1_t               s1_q;
    logic              s1_valid;
    logic              s2_valid;
    logic              s2_adv;
    logic              c4, c8, c12, c16;
    logic [GRP_N-1:0]  grp_cin;
    logic [DATA_W-1:0] carry;
    logic [DATA_W-1:0] sum_d;
    logic              zero_d;
`ifdef OVERFLOW_DETECT_EN
    logic              ovf_d;
`endif

    assign op = alu_op_e'(alu_op2);

    // Handshake: stage 2 moves when empty or its result is being taken;
    // stage 1 can take a beat when empty or it is moving into stage 2.
    // Depends only on state and out_ready, never on in_valid.
    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign out_valid = s2_valid;

    // Stage 1 combinational: condition b for subtract, form bit and group P/G.
    // NOTE: always_comb assigns every output on every path (defaults first) so no latch is inferred.
    always_comb begin
        pg_t pg;
        b_eff    = (op == ALU_SUB) ? ~b : b;
        s1_d.p   = a ^ b_eff;
        s1_d.g   = a & b_eff;
        s1_d.cin = (op == ALU_SUB);
        s1_d.gp  = '0;
        s1_d.gg  = '0;
        for (int j = 0; j < GRP_N; j++) begin
            pg          = group_pg(s1_d.p[j*GRP_W +: GRP_W], s1_d.g[j*GRP_W +: GRP_W]);
            s1_d.gp[j]  = pg.p;
            s1_d.gg[j]  = pg.g;
        end
    end

    // Stage 1 occupancy: refreshed whenever the stage can accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Stage 1 datapath register, loaded on an input handshake.
    // NOTE: no reset here -- contents are ignored until s1_valid is set, so the flops stay cheap.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_q <= s1_d;
        end
    end

    // Second-level lookahead for the group carries.
    cla_group_carry u_group_carry (
        .gp  (s1_q.gp),
        .gg  (s1_q.gg),
        .cin (s1_q.cin),
        .c4  (c4),
        .c8  (c8),
        .c12 (c12),
        .c16 (c16)
    );

    assign grp_cin = {c12, c8, c4, s1_q.cin};

    // Stage 2 combinational: ripple within each group from its lookahead carry-in.
    // NOTE: 'c' is a blocking scratch variable so each bit sees the carry just computed for the bit below.
    always_comb begin
        logic c;
        carry = '0;
        for (int j = 0; j < GRP_N; j++) begin
            c = grp_cin[j];
            for (int i = 0; i < GRP_W; i++) begin
                carry[j*GRP_W + i] = c;
                c = s1_q.g[j*GRP_W + i] | (s1_q.p[j*GRP_W + i] & c);
            end
        end
    end

    assign sum_d  = s1_q.p ^ carry;
    assign zero_d = (sum_d == '0);
`ifdef OVERFLOW_DETECT_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf_d  = c16 ^ carry[DATA_W-1];
`endif

    // Stage 2 / output register: loads only when advancing with a valid beat,
    // so a stalled result stays stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            zero     <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
            overflow <= 1'b0;
`endif
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sum      <= sum_d;
                cout     <= c16;
                zero     <= zero_d;
`ifdef OVERFLOW_DETECT_EN
                overflow <= ovf_d;
`endif
            end
        end
    end

    // Completed-operation counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_count <= '0;
        end else if (s2_valid && out_ready) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (built with CNT_W = 2 so the counter
// wraps quickly). The driver pushes hand-computed expected results when a
// beat is accepted; the monitor pops and compares on every output handshake.
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        alu_op2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        zero;
`ifdef OVERFLOW_DETECT_EN
    logic        overflow;
`endif
    logic [1:0]  op_count;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] sum;
        logic        cout;
        logic        zero;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        zero;
        logic        ovf;
    } exp_t;

    vec_t       vecs [11];
    exp_t       exp_q [$];
    exp_t       e;
    int         total = 0;
    int         bad   = 0;
    logic [1:0] exp_cnt = 2'd0;

    cla_pipe_adder #(.CNT_W(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op2   (alu_op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .zero      (zero),
`ifdef OVERFLOW_DETECT_EN
        .overflow  (overflow),
`endif
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vop,
                                input logic [15:0] vs, input logic vc, input logic vz,
                                input logic vo);
        vec_t v;
        v.a = va; v.b = vb; v.op = vop; v.sum = vs; v.cout = vc; v.zero = vz; v.ovf = vo;
        return v;
    endfunction

    task automatic offer(input int i);
        a        = vecs[i].a;
        b        = vecs[i].b;
        alu_op2  = vecs[i].op;
        in_valid = 1'b1;
    endtask

    // Wait (bounded) for in_ready, then record the expected result at the accepting edge.
    task automatic wait_accept(input int i);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: vector %0d never accepted", i);
            @(posedge clk);
        end else begin
            @(posedge clk);
            exp_q.push_back('{vecs[i].sum, vecs[i].cout, vecs[i].zero, vecs[i].ovf});
        end
        #1 in_valid = 1'b0;
    endtask

    // Monitor: compare every output handshake against the scoreboard head.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_cnt = 2'd0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: sum=%0h with nothing expected", sum);
            end else begin
                e = exp_q.pop_front();
                check("sum", sum, e.sum);
                check("cout", cout, e.cout);
                check("zero", zero, e.zero);
`ifdef OVERFLOW_DETECT_EN
                check("overflow", overflow, e.ovf);
`endif
                check("op_count_at_hs", op_count, exp_cnt);
                exp_cnt = exp_cnt + 2'd1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        //               a         b         op    sum       c     z     ovf
        vecs[0]  = mk(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
        vecs[1]  = mk(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        vecs[2]  = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        vecs[3]  = mk(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
        vecs[7]  = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        vecs[8]  = mk(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1, 1'b0, 1'b0);
        vecs[10] = mk(16'h0001, 16'h8000, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b1);

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        alu_op2   = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_op_count", op_count, 2'd0);
        check("rst_sum", sum, 16'h0000);
        #9 reset_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_rst", in_ready, 1'b1);

        // Single beat: out_valid exactly two cycles after the accept.
        out_ready = 1'b1;
        offer(0);
        wait_accept(0);
        @(negedge clk);
        check("latency_cycle1", out_valid, 1'b0);
        @(negedge clk);
        check("latency_cycle2", out_valid, 1'b1);
        @(posedge clk); #1;

        // Back-to-back stream with the consumer always ready.
        for (int i = 1; i <= 5; i++) begin
            offer(i);
            wait_accept(i);
        end
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure: third beat refused while both stages are full.
        out_ready = 1'b0;
        offer(6);
        wait_accept(6);
        offer(7);
        wait_accept(7);
        offer(8);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_sum_stable", sum, 16'h7FFF);
            check("bp_cout_stable", cout, 1'b1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_accept(8);
        @(negedge clk);
        check("drain_valid_2nd", out_valid, 1'b1);
        check("drain_sum_2nd", sum, 16'h0000);
        @(negedge clk);
        check("drain_valid_3rd", out_valid, 1'b1);
        check("drain_sum_3rd", sum, 16'h1000);
        @(posedge clk); #1;
        check("op_count_pre_rst", op_count, 2'd1);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        offer(9);
        wait_accept(9);
        offer(10);
        wait_accept(10);
        check("full_in_ready", in_ready, 1'b0);
        check("full_out_valid", out_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_op_count", op_count, 2'd0);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_mid_rst", in_ready, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("no_stale_beat", out_valid, 1'b0);
        end

        // Five more handshakes: counter walks 1,2,3,0,1.
        @(posedge clk); #1;
        for (int i = 0; i <= 4; i++) begin
            offer(i);
            wait_accept(i);
        end
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                n++;
                @(posedge clk);
            end
        end
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        check("final_op_count", op_count, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
